// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU execution unit: operation encoding,
// main-decoder ALUOp values and the execution FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD    = 4'd0,
    SUB    = 4'd1,
    AND    = 4'd2,
    OR     = 4'd3,
    XOR    = 4'd4,
    SLT    = 4'd5,
    SLTU   = 4'd6,
    SLL    = 4'd7,
    SRL    = 4'd8,
    SRA    = 4'd9,
    PASS_B = 4'd10
  } alu_ctrl_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } exec_state_t;

  function automatic logic is_shift(input alu_ctrl_t ctrl);
    return (ctrl == SLL) || (ctrl == SRL) || (ctrl == SRA);
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decoder: ALUOp/opcode bit 5/funct3/funct7 bit 5
// to the RV32I ALU operation.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_ctrl_t  alu_ctrl_c
);

  always_comb begin
    alu_ctrl_c = ADD;
    case (alu_op)
      ALUOP_ADD:   alu_ctrl_c = ADD;
      ALUOP_SUB:   alu_ctrl_c = SUB;
      ALUOP_PASSB: alu_ctrl_c = PASS_B;
      default: begin
        case (funct3)
          // only R-type (op5=1) can select SUB; ADDI ignores funct7
          3'b000:  alu_ctrl_c = (op5 && funct7_5) ? SUB : ADD;
          3'b001:  alu_ctrl_c = SLL;
          3'b010:  alu_ctrl_c = SLT;
          3'b011:  alu_ctrl_c = SLTU;
          3'b100:  alu_ctrl_c = XOR;
          3'b101:  alu_ctrl_c = funct7_5 ? SRA : SRL;
          3'b110:  alu_ctrl_c = OR;
          default: alu_ctrl_c = AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I ALU execution unit: decodes and executes one operation per request and
// holds the result behind a valid/ready handshake; optional bit-serial shifter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_ITER = 0,
  parameter int unsigned SHAMT_W    = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic            op5,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam bit ITER = (SHIFT_ITER != 0);

  exec_state_t        state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic               zero_q, zero_d;
  logic [XLEN-1:0]    sh_val_q, sh_val_d;
  logic [SHAMT_W-1:0] sh_cnt_q, sh_cnt_d;
  alu_ctrl_t          sh_op_q, sh_op_d;

  alu_ctrl_t          ctrl_c;
  logic [SHAMT_W-1:0] shamt_c;
  logic [XLEN-1:0]    exec_c;
  logic [XLEN-1:0]    sh_step_c;
  logic               accept_c;
  logic               iter_start_c;

  alu_ctrl_dec u_dec (
    .alu_op     (alu_op),
    .op5        (op5),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .alu_ctrl_c (ctrl_c)
  );

  assign shamt_c      = src_b[SHAMT_W-1:0];
  // gating with rst_n keeps the unit from advertising readiness while held in reset
  assign in_ready     = rst_n && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept_c     = in_valid && in_ready;
  assign iter_start_c = ITER && accept_c && is_shift(ctrl_c) && (shamt_c != '0);

  // Single-cycle datapath
  always_comb begin
    exec_c = src_b;
    case (ctrl_c)
      ADD:     exec_c = src_a + src_b;
      SUB:     exec_c = src_a - src_b;
      AND:     exec_c = src_a & src_b;
      OR:      exec_c = src_a | src_b;
      XOR:     exec_c = src_a ^ src_b;
      SLT:     exec_c = XLEN'($signed(src_a) < $signed(src_b));
      SLTU:    exec_c = XLEN'(src_a < src_b);
      SLL:     exec_c = src_a << shamt_c;
      SRL:     exec_c = src_a >> shamt_c;
      SRA:     exec_c = XLEN'($signed(src_a) >>> shamt_c);
      default: exec_c = src_b;
    endcase
  end

  // One-bit shift step; SRA replicates the MSB, which is the original sign bit
  always_comb begin
    sh_step_c = sh_val_q;
    case (sh_op_q)
      SLL:     sh_step_c = {sh_val_q[XLEN-2:0], 1'b0};
      SRL:     sh_step_c = {1'b0, sh_val_q[XLEN-1:1]};
      default: sh_step_c = {sh_val_q[XLEN-1], sh_val_q[XLEN-1:1]};
    endcase
  end

  // Next state, result register and shifter control
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    sh_val_d    = sh_val_q;
    sh_cnt_d    = sh_cnt_q;
    sh_op_d     = sh_op_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (iter_start_c) begin
          state_d  = SHIFT;
          sh_val_d = src_a;
          sh_cnt_d = shamt_c;
          sh_op_d  = ctrl_c;
        end else if (accept_c) begin
          out_valid_d = 1'b1;
          result_d    = exec_c;
          zero_d      = (exec_c == '0);
        end
      end
      SHIFT: begin
        sh_val_d = sh_step_c;
        sh_cnt_d = sh_cnt_q - SHAMT_W'(1);
        if (sh_cnt_q == SHAMT_W'(1)) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          result_d    = sh_step_c;
          zero_d      = (sh_step_c == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      sh_val_q    <= '0;
      sh_cnt_q    <= '0;
      sh_op_q     <= SLL;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      sh_val_q    <= sh_val_d;
      sh_cnt_q    <= sh_cnt_d;
      sh_op_q     <= sh_op_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: a barrel-shift instance and an iterative-shift
// instance, driven by directed steps and random ops against an arithmetic model.
module tb_alu_exec_unit;

  logic             clk;
  logic             rst_n;
  logic [1:0]       alu_op;
  logic             op5;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic [31:0]      src_a;
  logic [31:0]      src_b;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [1:0][31:0] result;
  logic [1:0]       zero;
  logic [1:0]       busy;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  logic [31:0] last_exp [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .SHIFT_ITER(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .alu_op(alu_op), .op5(op5), .funct3(funct3), .funct7_5(funct7_5),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(result[0]), .zero(zero[0]), .busy(busy[0])
  );

  alu_exec_unit #(.XLEN(32), .SHIFT_ITER(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .alu_op(alu_op), .op5(op5), .funct3(funct3), .funct7_5(funct7_5),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(result[1]), .zero(zero[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: RV32I semantics from plain 64-bit integer arithmetic
  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic o5,
      input logic [2:0] f3, input logic f7, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, p, m;
    int s;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = int'(b[4:0]);
    p  = longint'(1) << s;
    m  = ((sa % p) + p) % p;
    if (op == 2'd0) return 32'(ua + ub);
    if (op == 2'd1) return 32'(ua - ub);
    if (op == 2'd3) return b;
    case (f3)
      3'd0:    return (o5 && f7) ? 32'(ua - ub) : 32'(ua + ub);
      3'd1:    return 32'(ua * p);
      3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
      3'd3:    return (ua < ub) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return f7 ? 32'((sa - m) / p) : 32'(ua / p);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Issue one op on DUT sel; optionally stall the previous result for hold cycles
  // first, and optionally wave a stray request while the shifter is busy.
  task automatic run_op(input int sel, input logic [1:0] op, input logic o5,
      input logic [2:0] f3, input logic f7, input logic [31:0] a, input logic [31:0] b,
      input int hold, input bit noise, input string tag);
    logic [31:0] exp;
    int lat;
    int waited;
    exp = ref_alu(op, o5, f3, f7, a, b);
    lat = (sel == 1 && op == 2'd2 && (f3 == 3'd1 || f3 == 3'd5) && b[4:0] != 5'd0)
          ? int'(b[4:0]) + 1 : 1;
    alu_op = op; op5 = o5; funct3 = f3; funct7_5 = f7; src_a = a; src_b = b;
    in_valid[sel] = 1'b1;
    if (hold > 0) begin
      out_ready[sel] = 1'b0;
      for (int i = 0; i < hold; i++) begin
        #1;
        chk({tag, ":stall_rdy"}, 64'(in_ready[sel]), 64'd0);
        chk({tag, ":stall_vld"}, 64'(out_valid[sel]), 64'd1);
        chk({tag, ":stall_res"}, 64'(result[sel]), 64'(last_exp[sel]));
        chk({tag, ":stall_zero"}, 64'(zero[sel]), 64'(last_exp[sel] == 32'd0));
        chk({tag, ":stall_busy"}, 64'(busy[sel]), 64'd0);
        @(posedge clk); #1;
      end
      out_ready[sel] = 1'b1;
    end
    #1;
    waited = 0;
    while (!in_ready[sel] && waited < 64) begin
      @(posedge clk); #1;
      waited++;
    end
    chk({tag, ":acc"}, 64'(in_ready[sel]), 64'd1);
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    for (int i = 1; i < lat; i++) begin
      if (noise && i == 1) begin
        in_valid[sel] = 1'b1; alu_op = 2'b00; src_a = ~a;
      end
      chk({tag, ":busy"}, 64'(busy[sel]), 64'd1);
      chk({tag, ":busy_rdy"}, 64'(in_ready[sel]), 64'd0);
      chk({tag, ":busy_vld"}, 64'(out_valid[sel]), 64'd0);
      @(posedge clk); #1;
    end
    in_valid[sel] = 1'b0;
    chk({tag, ":vld"}, 64'(out_valid[sel]), 64'd1);
    chk({tag, ":res"}, 64'(result[sel]), 64'(exp));
    chk({tag, ":zero"}, 64'(zero[sel]), 64'(exp == 32'd0));
    chk({tag, ":idle"}, 64'(busy[sel]), 64'd0);
    last_exp[sel] = exp;
    if (noise) begin
      @(posedge clk); #1;
      chk({tag, ":no_latch"}, 64'(out_valid[sel]), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_sel;
    rst_n = 1'b0; in_valid = 2'b00; out_ready = 2'b11;
    alu_op = 2'b00; op5 = 1'b0; funct3 = 3'd0; funct7_5 = 1'b0; src_a = '0; src_b = '0;
    last_exp[0] = '0; last_exp[1] = '0;
    #12;
    for (int s = 0; s < 2; s++) begin
      chk("rst_vld", 64'(out_valid[s]), 64'd0);
      chk("rst_res", 64'(result[s]), 64'd0);
      chk("rst_zero", 64'(zero[s]), 64'd0);
      chk("rst_busy", 64'(busy[s]), 64'd0);
      chk("rst_rdy", 64'(in_ready[s]), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rdy0", 64'(in_ready[0]), 64'd1);
    chk("post_rst_rdy1", 64'(in_ready[1]), 64'd1);

    run_op(0, 2'b00, 1'b0, 3'd0, 1'b0, 32'h7FFF_FFFF, 32'h1, 0, 0, "add_wrap");
    chk("add_wrap_const", 64'(result[0]), 64'h8000_0000);
    run_op(0, 2'b10, 1'b1, 3'd0, 1'b1, 32'd5, 32'd5, 0, 0, "sub_zero");
    run_op(0, 2'b10, 1'b0, 3'd0, 1'b1, 32'd5, 32'd5, 0, 0, "addi");
    chk("addi_const", 64'(result[0]), 64'd10);
    run_op(0, 2'b10, 1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0, "slt");
    run_op(0, 2'b10, 1'b1, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0, "sltu");
    run_op(0, 2'b01, 1'b0, 3'd0, 1'b0, 32'd3, 32'd7, 0, 0, "sub_neg");
    run_op(0, 2'b11, 1'b0, 3'd0, 1'b0, 32'd3, 32'hABCD_E000, 0, 0, "lui");
    run_op(0, 2'b10, 1'b1, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 0, 0, "sra_barrel");

    run_op(1, 2'b10, 1'b1, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 0, 0, "sra_iter");
    chk("sra_iter_const", 64'(result[1]), 64'hF800_0000);
    run_op(1, 2'b10, 1'b1, 3'd5, 1'b1, 32'h8000_0000, 32'h20, 0, 0, "sra_shamt0");
    run_op(1, 2'b10, 1'b1, 3'd1, 1'b0, 32'h0000_00F1, 32'd31, 0, 0, "sll_max");
    run_op(1, 2'b10, 1'b1, 3'd5, 1'b0, 32'hF000_0000, 32'd6, 0, 1, "srl_noise");

    run_op(0, 2'b10, 1'b1, 3'd4, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 0, 0, "bp_pre0");
    run_op(0, 2'b10, 1'b1, 3'd6, 1'b0, 32'h1200_0000, 32'h0000_0034, 3, 0, "bp0");
    run_op(1, 2'b10, 1'b1, 3'd7, 1'b0, 32'hFFFF_0000, 32'h00FF_FF00, 0, 0, "bp_pre1");
    run_op(1, 2'b10, 1'b1, 3'd1, 1'b0, 32'h0000_0003, 32'd5, 3, 0, "bp1_shift");

    // Reset in the middle of an iterative shift
    alu_op = 2'b10; op5 = 1'b1; funct3 = 3'd5; funct7_5 = 1'b0;
    src_a = 32'hFFFF_FFFF; src_b = 32'd10; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_busy", 64'(busy[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(out_valid[1]), 64'd0);
    chk("mid_rst_busy", 64'(busy[1]), 64'd0);
    chk("mid_rst_res", 64'(result[1]), 64'd0);
    chk("mid_rst_rdy", 64'(in_ready[1]), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    chk("mid_rst_nores", 64'(out_valid[1]), 64'd0);
    last_exp[0] = '0; last_exp[1] = '0;
    run_op(1, 2'b10, 1'b1, 3'd1, 1'b0, 32'h0000_0011, 32'd3, 0, 0, "after_rst");

    prev_sel = -1;
    for (int i = 0; i < 160; i++) begin
      int sel;
      int hold;
      logic [31:0] a, b;
      sel = int'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'(b + 32'($urandom_range(0, 1)));
      hold = (sel == prev_sel && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(sel, 2'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), a, b,
             hold, 0, "rand");
      prev_sel = sel;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
